// File: rtl/wb_write_queue.sv
// wb_write_queue
//
// Write-back queue in front of the single register-file write port. Completed
// results from the memory-load path (older) and the ALU path (younger) are
// buffered in program order and retired one register write per clock through
// registered outputs. Also flags read-after-write hazards for the two register
// addresses currently being decoded.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   mem_valid/dest/result     load result (older when both sources are valid)
//   alu_valid/dest/result     ALU result (younger)
//   in_ready                  queue can take up to two entries this cycle
//   src1, src2                decode read addresses
//   src1_pending/src2_pending a queued or in-flight write targets srcN
//   Dest_wb, Result_WB        register-file write address / data
//   writeBackEn               register-file write strobe

module wb_write_queue #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic [REG_ADDR_LEN-1:0] mem_dest,
  input  logic [WORD_LEN-1:0]     mem_result,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_LEN-1:0] alu_dest,
  input  logic [WORD_LEN-1:0]     alu_result,
  output logic                    in_ready,
  input  logic [REG_ADDR_LEN-1:0] src1,
  input  logic [REG_ADDR_LEN-1:0] src2,
  output logic                    src1_pending,
  output logic                    src2_pending,
  output logic [REG_ADDR_LEN-1:0] Dest_wb,
  output logic [WORD_LEN-1:0]     Result_WB,
  output logic                    writeBackEn
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - 2);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // FIFO storage; contents are never reset, occupancy is tracked by count_q.
  logic [REG_ADDR_LEN-1:0] dest_q [DEPTH];
  logic [WORD_LEN-1:0]     data_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic       enq_mem, enq_alu, deq;
  logic [1:0] num_enq;
  ptr_t       alu_slot;

  // Ready looks only at the registered count so it never depends on a drain.
  assign in_ready = (count_q <= ReadyMax);

  always_comb begin
    enq_mem  = mem_valid & in_ready;
    enq_alu  = alu_valid & in_ready;
    num_enq  = {1'b0, enq_mem} + {1'b0, enq_alu};
    deq      = (count_q != '0);
    // With both sources valid the younger ALU entry lands one slot after mem.
    alu_slot = tail_q + ptr_t'(enq_mem);
    tail_d   = tail_q + ptr_t'(num_enq);
    head_d   = head_q + ptr_t'(deq);
    count_d  = count_q + cnt_t'(num_enq) - cnt_t'(deq);
  end

  always_ff @(posedge clk) begin
    if (enq_mem) begin
      dest_q[tail_q] <= mem_dest;
      data_q[tail_q] <= mem_result;
    end
    if (enq_alu) begin
      dest_q[alu_slot] <= alu_dest;
      data_q[alu_slot] <= alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
      writeBackEn <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      writeBackEn <= deq;
      // Output registers hold their last values while the queue is idle.
      if (deq) begin
        Dest_wb   <= dest_q[head_q];
        Result_WB <= data_q[head_q];
      end
    end
  end

  // Hazard check over occupied slots (head .. head+count-1) plus the write
  // currently presented to the register file. Register 0 is not special.
  always_comb begin
    ptr_t idx;
    idx          = '0;
    src1_pending = writeBackEn && (Dest_wb == src1);
    src2_pending = writeBackEn && (Dest_wb == src2);
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + ptr_t'(i);
      if (cnt_t'(i) < count_q) begin
        if (dest_q[idx] == src1) src1_pending = 1'b1;
        if (dest_q[idx] == src2) src2_pending = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [3:0]  mem_dest, alu_dest;
  logic [31:0] mem_result, alu_result;
  logic        in_ready;
  logic [3:0]  src1, src2;
  logic        src1_pending, src2_pending;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        writeBackEn;

  int n_checks = 0;
  int n_pass   = 0;

  wb_write_queue #(
    .WORD_LEN    (32),
    .REG_ADDR_LEN(4),
    .DEPTH       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_dest    (mem_dest),
    .mem_result  (mem_result),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_result  (alu_result),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .src1_pending(src1_pending),
    .src2_pending(src2_pending),
    .Dest_wb     (Dest_wb),
    .Result_WB   (Result_WB),
    .writeBackEn (writeBackEn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic mv, input logic [3:0] md, input logic [31:0] mr,
                       input logic av, input logic [3:0] ad, input logic [31:0] ar);
    mem_valid = mv; mem_dest = md; mem_result = mr;
    alu_valid = av; alu_dest = ad; alu_result = ar;
  endtask

  initial begin
    int          cnt, pairs_left, e, cyc, n;
    logic        rdy, dq;
    logic [35:0] sb[$];
    logic [35:0] item;

    rst = 1'b1;
    src1 = 4'd0; src2 = 4'd0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    src1 = 4'd9; src2 = 4'd10;
    #1;
    check("rst_wben",   writeBackEn, 0);
    check("rst_dest",   Dest_wb, 0);
    check("rst_result", Result_WB, 0);
    check("rst_ready",  in_ready, 1);
    check("rst_pend1",  src1_pending, 0);

    // Single ALU op, dest 5, data 0xB.
    step();
    src1 = 4'd5;
    drive(0, 0, 0, 1, 4'd5, 32'h0000_000B);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("alu_wben_early", writeBackEn, 0);
    check("alu_pend_q",     src1_pending, 1);
    step();
    check("alu_wben",   writeBackEn, 1);
    check("alu_dest",   Dest_wb, 5);
    check("alu_result", Result_WB, 32'hB);
    check("alu_pend_w", src1_pending, 1);
    step();
    check("alu_wben_off", writeBackEn, 0);
    check("alu_pend_off", src1_pending, 0);
    check("alu_hold",     Dest_wb, 5);

    // Simultaneous mem+alu to the same destination: mem retires first.
    src1 = 4'd3;
    drive(1, 4'd3, 32'h11, 1, 4'd3, 32'h22);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("pair_wben0", writeBackEn, 0);
    check("pair_pend0", src1_pending, 1);
    step();
    check("pair_wben1", writeBackEn, 1);
    check("pair_dest1", Dest_wb, 3);
    check("pair_res1",  Result_WB, 32'h11);
    check("pair_pend1", src1_pending, 1);
    step();
    check("pair_wben2", writeBackEn, 1);
    check("pair_res2",  Result_WB, 32'h22);
    check("pair_pend2", src1_pending, 1);
    step();
    check("pair_wben3", writeBackEn, 0);
    check("pair_pend3", src1_pending, 0);

    // Hazard on dest 7, then idle hold of the last write.
    src1 = 4'd7; src2 = 4'd2;
    drive(0, 0, 0, 1, 4'd7, 32'h22);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("haz_pend1", src1_pending, 1);
    check("haz_pend2", src2_pending, 0);
    step();
    check("haz_wben", writeBackEn, 1);
    check("haz_dest", Dest_wb, 7);
    step();
    check("haz_clear",   src1_pending, 0);
    check("idle_wben",   writeBackEn, 0);
    check("idle_dest",   Dest_wb, 7);
    check("idle_result", Result_WB, 32'h22);
    step();
    check("idle_hold", Result_WB, 32'h22);

    // Backpressure: pairs whenever ready, illegal pairs while not ready.
    cnt = 0; pairs_left = 7; e = 0; cyc = 0;
    while ((pairs_left > 0 || cnt > 0) && cyc < 60) begin
      rdy = (cnt <= 2);
      check("bp_ready", in_ready, rdy);
      n = 0;
      if (rdy && pairs_left > 0) begin
        drive(1, 4'(e), 32'(32'hA000 + e), 1, 4'(e + 1), 32'(32'hA000 + e + 1));
        sb.push_back({4'(e), 32'(32'hA000 + e)});
        sb.push_back({4'(e + 1), 32'(32'hA000 + e + 1)});
        e += 2;
        pairs_left--;
        n = 2;
      end else if (!rdy) begin
        drive(1, 4'hF, 32'hDEAD_0001, 1, 4'hE, 32'hDEAD_0002);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      dq = (cnt > 0);
      step();
      check("bp_wben", writeBackEn, dq);
      if (dq) begin
        item = sb.pop_front();
        check("bp_dest",   Dest_wb, item[35:32]);
        check("bp_result", Result_WB, item[31:0]);
      end
      cnt = cnt + n - int'(dq);
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0);
    check("bp_in_time", cyc < 60, 1);
    step();
    check("bp_idle", writeBackEn, 0);

    // Reset mid-drain with three entries queued.
    drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h2);
    step();
    drive(1, 4'd4, 32'h4, 1, 4'd6, 32'h6);
    step();
    drive(0, 0, 0, 0, 0, 0);
    src1 = 4'd6;
    #1;
    check("mid_pend_before", src1_pending, 1);
    check("mid_ready_before", in_ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_wben",   writeBackEn, 0);
    check("mid_rst_dest",   Dest_wb, 0);
    check("mid_rst_result", Result_WB, 0);
    check("mid_rst_ready",  in_ready, 1);
    check("mid_rst_pend",   src1_pending, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_wben", writeBackEn, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
